// File: rtl/bcd_countdown_controller.sv
// bcd_countdown_controller: loadable BCD countdown timer with a run/pause/expire FSM.
// Ports:
//   Clk        system clock, all state updates on posedge
//   Clear      asynchronous active-high reset
//   Tick       count-enable strobe, one Clk cycle wide
//   Start      start/resume request pulse
//   Stop       pause/abort request pulse
//   Load       load preset pulse (LoadValue, nibbles >9 clamp to 9)
//   LoadValue  preset, packed BCD, digit 0 in [3:0]
//   Count      current packed-BCD value (registered)
//   State      00 IDLE, 01 RUN, 10 PAUSE, 11 DONE (registered)
//   Running    high in RUN only
//   Alarm      high in DONE only
//   Expired    one-cycle pulse on entry to DONE
module bcd_countdown_controller #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Clear,
  input  logic                  Tick,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  output logic [4*DIGITS-1:0]   Count,
  output logic [1:0]            State,
  output logic                  Running,
  output logic                  Alarm,
  output logic                  Expired
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   count_d;
  logic           expired_d;
  logic [W-1:0]   load_clamped;
  logic [W-1:0]   count_dec;
  logic           count_zero;
  logic           dec_zero;

  // Per-digit clamp of the preset so Count never holds A..F.
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (LoadValue[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
      else                            load_clamped[4*i +: 4] = LoadValue[4*i +: 4];
    end
  end

  // Ripple-borrow BCD decrement: a zero digit becomes 9 and passes the borrow up.
  always_comb begin
    logic borrow;
    count_dec = Count;
    borrow    = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (Count[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = Count[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  assign count_zero = (Count == '0);
  assign dec_zero   = (count_dec == '0);

  // Next-state logic; priority Load > Stop > Start > Tick, each only where it acts.
  always_comb begin
    state_d   = state_q;
    count_d   = Count;
    expired_d = 1'b0;
    if (Load) begin
      count_d = load_clamped;
      state_d = IDLE;
    end else if (Stop && (state_q != IDLE)) begin
      state_d = (state_q == RUN) ? PAUSE : IDLE;
    end else if (Start && ((state_q == IDLE) || (state_q == PAUSE))) begin
      if (count_zero) begin
        state_d   = DONE;
        expired_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (Tick && (state_q == RUN)) begin
      // A forced Tick at zero also lands in DONE with Count held at 0.
      if (count_zero || dec_zero) begin
        count_d   = '0;
        state_d   = DONE;
        expired_d = 1'b1;
      end else begin
        count_d = count_dec;
      end
    end
  end

  // State, count and decoded status all update on the same edge.
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q <= IDLE;
      Count   <= '0;
      Running <= 1'b0;
      Alarm   <= 1'b0;
      Expired <= 1'b0;
    end else begin
      state_q <= state_d;
      Count   <= count_d;
      Running <= (state_d == RUN);
      Alarm   <= (state_d == DONE);
      Expired <= expired_d;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_bcd_countdown_controller.sv
// Directed self-checking bench for bcd_countdown_controller (DIGITS=4).
module tb_bcd_countdown_controller;

  logic        Clk;
  logic        Clear;
  logic        Tick;
  logic        Start;
  logic        Stop;
  logic        Load;
  logic [15:0] LoadValue;
  logic [15:0] Count;
  logic [1:0]  State;
  logic        Running;
  logic        Alarm;
  logic        Expired;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_countdown_controller #(.DIGITS(4)) dut (
    .Clk(Clk), .Clear(Clear), .Tick(Tick), .Start(Start), .Stop(Stop),
    .Load(Load), .LoadValue(LoadValue), .Count(Count), .State(State),
    .Running(Running), .Alarm(Alarm), .Expired(Expired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of commands, then sample 1 time unit after the edge.
  task automatic step(input logic ld, input logic [15:0] lv, input logic st,
                      input logic sp, input logic tk);
    Load = ld; LoadValue = lv; Start = st; Stop = sp; Tick = tk;
    @(posedge Clk);
    #1;
    Load = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [15:0] c, input logic [1:0] s,
                           input logic r, input logic a, input logic e);
    check({tag, ".count"},   32'(Count),   32'(c));
    check({tag, ".state"},   32'(State),   32'(s));
    check({tag, ".running"}, 32'(Running), 32'(r));
    check({tag, ".alarm"},   32'(Alarm),   32'(a));
    check({tag, ".expired"}, 32'(Expired), 32'(e));
  endtask

  initial begin
    Clear = 1'b1; Tick = 1'b0; Start = 1'b0; Stop = 1'b0; Load = 1'b0; LoadValue = 16'h0;
    #3;
    check_all("reset", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    #4 Clear = 1'b0;

    // Borrow across digits 0 and 1.
    step(1, 16'h0103, 0, 0, 0); check_all("ld103",  16'h0103, 2'b00, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);    check_all("st103",  16'h0103, 2'b01, 1, 0, 0);
    step(0, 16'h0, 0, 0, 1);    check_all("t1",     16'h0102, 2'b01, 1, 0, 0);
    step(0, 16'h0, 0, 0, 1);    check_all("t2",     16'h0101, 2'b01, 1, 0, 0);
    step(0, 16'h0, 0, 0, 1);    check_all("t3",     16'h0100, 2'b01, 1, 0, 0);
    step(0, 16'h0, 0, 0, 1);    check_all("t4",     16'h0099, 2'b01, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);    check_all("st_in_run", 16'h0099, 2'b01, 1, 0, 0);

    // Asynchronous clear mid-run, observed between clock edges.
    step(1, 16'h0042, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);    check_all("run42",  16'h0042, 2'b01, 1, 0, 0);
    #2 Clear = 1'b1;
    #1 check_all("aclr",        16'h0000, 2'b00, 0, 0, 0);
    #2 Clear = 1'b0;
    @(posedge Clk); #1;
    check_all("post_clr",       16'h0000, 2'b00, 0, 0, 0);

    // Expiry and alarm.
    step(1, 16'h0002, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 0, 0, 1);    check_all("e1",     16'h0001, 2'b01, 1, 0, 0);
    step(0, 16'h0, 0, 0, 1);    check_all("e0",     16'h0000, 2'b11, 0, 1, 1);
    step(0, 16'h0, 0, 0, 1);    check_all("done_t", 16'h0000, 2'b11, 0, 1, 0);
    step(0, 16'h0, 1, 0, 1);    check_all("done_s", 16'h0000, 2'b11, 0, 1, 0);
    step(0, 16'h0, 0, 1, 0);    check_all("done_p", 16'h0000, 2'b00, 0, 0, 0);

    // Pause ignores ticks, resume continues.
    step(1, 16'h0050, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 16'h0, 0, 0, 1);
    check_all("p47",            16'h0047, 2'b01, 1, 0, 0);
    step(0, 16'h0, 0, 1, 0);    check_all("pause",  16'h0047, 2'b10, 0, 0, 0);
    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1);    check_all("p_tick", 16'h0047, 2'b10, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);    check_all("resume", 16'h0047, 2'b01, 1, 0, 0);
    step(0, 16'h0, 0, 0, 1);    check_all("p46",    16'h0046, 2'b01, 1, 0, 0);
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 1, 0);    check_all("pz_idle", 16'h0046, 2'b00, 0, 0, 0);

    // Sanitising and start at zero.
    step(1, 16'h1F5A, 0, 0, 0); check_all("clamp",  16'h1959, 2'b00, 0, 0, 0);
    step(1, 16'hFFFF, 0, 0, 0); check_all("clampF", 16'h9999, 2'b00, 0, 0, 0);
    step(1, 16'h0000, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);    check_all("zstart", 16'h0000, 2'b11, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0);    check_all("zhold",  16'h0000, 2'b11, 0, 1, 0);
    step(1, 16'h0003, 0, 0, 0); check_all("ld_done", 16'h0003, 2'b00, 0, 0, 0);

    // Simultaneous commands.
    step(1, 16'h0010, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 0, 1, 0);    check_all("s_pause", 16'h0010, 2'b10, 0, 0, 0);
    step(0, 16'h0, 1, 0, 1);    check_all("st_tk",  16'h0010, 2'b01, 1, 0, 0);
    step(0, 16'h0, 0, 1, 1);    check_all("sp_tk",  16'h0010, 2'b10, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    step(1, 16'h0007, 0, 1, 1); check_all("ld_sp_tk", 16'h0007, 2'b00, 0, 0, 0);
    step(0, 16'h0, 1, 1, 0);    check_all("idle_sp_st", 16'h0007, 2'b01, 1, 0, 0);
    step(0, 16'h0, 0, 0, 1);    check_all("last",   16'h0006, 2'b01, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
